// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and arbiter state encoding for the
// register-file writeback arbiter.
package rf_wb_arbiter_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic {
    WB_LAST_ALU = 1'b0,
    WB_LAST_LSU = 1'b1
  } wb_state_e;
endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register,
// set at issue, cleared at commit, three combinational lookups.
import rf_wb_arbiter_pkg::*;

module wb_scoreboard (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_idx,
  input  logic [REG_AW-1:0]   rs1_idx,
  input  logic [REG_AW-1:0]   rs2_idx,
  input  logic [REG_AW-1:0]   rd_idx,
  output logic                rs1_pend,
  output logic                rs2_pend,
  output logic                rd_pend,
  output logic [NUM_REGS-1:0] mask
);
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;

  // set applied after clear: a newer writer outranks the retiring one
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign rs1_pend = pend[rs1_idx];
  assign rs2_pend = pend[rs2_idx];
  assign rd_pend  = pend[rd_idx];
  assign mask     = pend;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port
// plus RAW/WAW issue stall from the pending scoreboard.
import rf_wb_arbiter_pkg::*;

module rf_wb_arbiter (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                alu_wb_valid,
  output logic                alu_wb_ready,
  input  logic [REG_AW-1:0]   alu_wb_rd,
  input  logic [XLEN-1:0]     alu_wb_data,
  input  logic                lsu_wb_valid,
  output logic                lsu_wb_ready,
  input  logic [REG_AW-1:0]   lsu_wb_rd,
  input  logic [XLEN-1:0]     lsu_wb_data,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic [REG_AW-1:0]   issue_rs2,
  output logic                issue_stall,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0] pending_mask
);
  wb_state_e state;
  logic      alu_gnt;
  logic      lsu_gnt;
  logic      rs1_pend;
  logic      rs2_pend;
  logic      rd_pend;
  logic      set_en;

  assign alu_gnt = !halt && alu_wb_valid &&
                   (!lsu_wb_valid || state == WB_LAST_LSU);
  assign lsu_gnt = !halt && lsu_wb_valid &&
                   (!alu_wb_valid || state == WB_LAST_ALU);

  assign alu_wb_ready = alu_gnt;
  assign lsu_wb_ready = lsu_gnt;

  assign issue_stall = halt ||
    (issue_valid && (rs1_pend || rs2_pend || rd_pend));
  assign set_en = issue_valid && !issue_stall &&
                  (issue_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WB_LAST_LSU;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (1'b1)
        alu_gnt: begin
          state    <= WB_LAST_ALU;
          rf_we    <= (alu_wb_rd != '0);
          rf_waddr <= alu_wb_rd;
          rf_wdata <= alu_wb_data;
        end
        lsu_gnt: begin
          state    <= WB_LAST_LSU;
          rf_we    <= (lsu_wb_rd != '0);
          rf_waddr <= lsu_wb_rd;
          rf_wdata <= lsu_wb_data;
        end
        default: ;
      endcase
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_idx  (issue_rd),
    .clr_en   (rf_we),
    .clr_idx  (rf_waddr),
    .rs1_idx  (issue_rs1),
    .rs2_idx  (issue_rs2),
    .rd_idx   (issue_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .mask     (pending_mask)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed cycle-table bench for rf_wb_arbiter plus a
// hand-written stall-release sequence.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, halt;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        issue_valid, issue_stall;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_stall  (issue_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  typedef struct {
    logic        r, h;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird, is1, is2;
    logic        e_ar, e_lr, e_st, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_m;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic r, h,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [4:0] ird, is1, is2,
    input logic e_ar, e_lr, e_st, e_we,
    input logic [4:0] e_wa, input logic [31:0] e_wd, e_m);
    vec_t v;
    v.r = r; v.h = h;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.is1 = is1; v.is2 = is2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_st = e_st; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_m = e_m;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; halt = v.h;
    alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.ad;
    lsu_wb_valid = v.lv; lsu_wb_rd = v.lrd; lsu_wb_data = v.ld;
    issue_valid = v.iv; issue_rd = v.ird;
    issue_rs1 = v.is1; issue_rs2 = v.is2;
  endtask

  initial begin
    vec_t idle;
    bit ok;
    int nst;
    bit done;

    idle = '{r:1'b0, h:1'b0, av:1'b0, ard:5'd0, ad:32'd0,
             lv:1'b0, lrd:5'd0, ld:32'd0, iv:1'b0, ird:5'd0,
             is1:5'd0, is2:5'd0, e_ar:1'b0, e_lr:1'b0,
             e_st:1'b0, e_we:1'b0, e_wa:5'd0, e_wd:32'd0,
             e_m:32'd0};
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //   r h  av ard ad            lv lrd ld        iv ird rs1 rs2  ar lr st we wa wd            mask
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 0 reset
    add(0,0, 1,5,32'hDEADBEEF,   0,0,0,          0,0,0,0,   1,0,0,0, 0,0,             32'h0);   // 1
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,1, 5,32'hDEADBEEF,  32'h0);   // 2
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 3
    add(1,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 4 rst
    add(0,0, 1,3,32'h33,         1,4,32'h44,     0,0,0,0,   1,0,0,0, 0,0,             32'h0);   // 5
    add(0,0, 1,3,32'h33,         1,4,32'h44,     0,0,0,0,   0,1,0,1, 3,32'h33,        32'h0);   // 6
    add(0,0, 1,3,32'h33,         1,4,32'h44,     0,0,0,0,   1,0,0,1, 4,32'h44,        32'h0);   // 7
    add(0,0, 1,3,32'h33,         1,4,32'h44,     0,0,0,0,   0,1,0,1, 3,32'h33,        32'h0);   // 8
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,1, 4,32'h44,        32'h0);   // 9
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 10
    add(0,0, 0,0,0,              1,0,32'h1,      0,0,0,0,   0,1,0,0, 0,0,             32'h0);   // 11 x0
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 12
    add(0,0, 0,0,0,              0,0,0,          1,7,0,0,   0,0,0,0, 0,0,             32'h0);   // 13
    add(0,0, 0,0,0,              0,0,0,          1,0,7,0,   0,0,1,0, 0,0,             32'h80);  // 14
    add(0,0, 1,7,32'h77,         0,0,0,          1,0,7,0,   1,0,1,0, 0,0,             32'h80);  // 15
    add(0,0, 0,0,0,              0,0,0,          1,0,7,0,   0,0,1,1, 7,32'h77,        32'h80);  // 16
    add(0,0, 0,0,0,              0,0,0,          1,0,7,0,   0,0,0,0, 0,0,             32'h0);   // 17
    add(0,0, 0,0,0,              0,0,0,          1,9,0,0,   0,0,0,0, 0,0,             32'h0);   // 18
    add(0,0, 1,9,32'h99,         0,0,0,          0,0,0,0,   1,0,0,0, 0,0,             32'h200); // 19
    add(0,0, 0,0,0,              0,0,0,          1,9,0,0,   0,0,1,1, 9,32'h99,        32'h200); // 20
    add(0,0, 0,0,0,              0,0,0,          1,9,0,0,   0,0,0,0, 0,0,             32'h0);   // 21
    add(0,0, 0,0,0,              1,9,32'h1234,   0,0,0,0,   0,1,0,0, 0,0,             32'h200); // 22
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,1, 9,32'h1234,      32'h200); // 23
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 24
    add(0,1, 1,3,32'hA,          1,4,32'hB,      1,8,0,0,   0,0,1,0, 0,0,             32'h0);   // 25 halt
    add(0,0, 1,3,32'hA,          1,4,32'hB,      0,0,0,0,   1,0,0,0, 0,0,             32'h0);   // 26
    add(0,1, 0,0,0,              0,0,0,          0,0,0,0,   0,0,1,1, 3,32'hA,         32'h0);   // 27
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 28
    add(0,0, 0,0,0,              0,0,0,          1,8,0,0,   0,0,0,0, 0,0,             32'h0);   // 29
    add(0,0, 0,0,0,              0,0,0,          1,9,0,0,   0,0,0,0, 0,0,             32'h100); // 30
    add(0,0, 0,0,0,              0,0,0,          1,10,0,0,  0,0,0,0, 0,0,             32'h300); // 31
    add(0,0, 0,0,0,              0,0,0,          1,11,0,0,  0,0,0,0, 0,0,             32'h700); // 32
    add(1,0, 1,8,32'h88,         0,0,0,          0,0,0,0,   1,0,0,0, 0,0,             32'hF00); // 33 rst
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 34
    add(0,0, 1,3,32'h5,          1,4,32'h6,      0,0,0,0,   1,0,0,0, 0,0,             32'h0);   // 35
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,1, 3,32'h5,         32'h0);   // 36
    add(0,0, 0,0,0,              0,0,0,          0,0,0,0,   0,0,0,0, 0,0,             32'h0);   // 37

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      ok = (alu_wb_ready === tbl[i].e_ar) &&
           (lsu_wb_ready === tbl[i].e_lr) &&
           (issue_stall  === tbl[i].e_st) &&
           (rf_we        === tbl[i].e_we) &&
           (pending_mask === tbl[i].e_m);
      if (tbl[i].e_we)
        ok = ok && (rf_waddr === tbl[i].e_wa) &&
             (rf_wdata === tbl[i].e_wd);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL row%0d got ar=%b lr=%b st=%b we=%b wa=%0d wd=%h m=%h want ar=%b lr=%b st=%b we=%b wa=%0d wd=%h m=%h",
          i, alu_wb_ready, lsu_wb_ready, issue_stall, rf_we,
          rf_waddr, rf_wdata, pending_mask,
          tbl[i].e_ar, tbl[i].e_lr, tbl[i].e_st, tbl[i].e_we,
          tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_m);
      end
    end

    // RAW on r12: stall must last grant cycle + 1, then drop
    @(negedge clk);
    drive(idle);
    issue_valid = 1'b1; issue_rd = 5'd12;
    @(negedge clk);
    drive(idle);
    issue_valid = 1'b1; issue_rs1 = 5'd12;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd12;
    alu_wb_data = 32'hC0FFEE;
    nst = 0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        alu_wb_valid = 1'b0;
      end
      #1;
      if (issue_stall) nst++;
      else done = 1'b1;
    end
    n_cmp++;
    if (!done || nst != 2) begin
      n_bad++;
      $display("FAIL raw_release got stall_cycles=%0d done=%b want 2",
               nst, done);
    end

    @(negedge clk);
    drive(idle);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
